// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: instruction fetch stage with stall, branch redirect and sticky address fault.
module ifetch_ctrl #(
  parameter int          MEM_BYTES = 400,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Enable,
  input  logic        Stall,
  input  logic        BrTaken,
  input  logic [31:0] BrTarget,
  input  logic [31:0] ITM,
  output logic [31:0] RAdrs,
  output logic [31:0] Instr,
  output logic [31:0] PCOut,
  output logic        Valid,
  output logic        Fault,
  output logic [15:0] FetchCnt
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FAULT} state_t;
  state_t      state;
  logic [31:0] pc;
  logic        legal;
  assign RAdrs = pc;
  // 33-bit sum so an address near 2^32 cannot wrap into the legal range
  assign legal = (pc[1:0] == 2'b00) && (({1'b0, pc} + 33'd3) < 33'(MEM_BYTES));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      Instr    <= '0;
      PCOut    <= '0;
      Valid    <= 1'b0;
      Fault    <= 1'b0;
      FetchCnt <= '0;
    end else begin
      case (state)
        IDLE: if (Enable) state <= FETCH;
        FETCH, HOLD: begin
          if (!Enable) begin
            state <= IDLE;
            Valid <= 1'b0;
            if (BrTaken) pc <= BrTarget;
          end else if (BrTaken) begin
            pc    <= BrTarget;
            Valid <= 1'b0;
            state <= FETCH;
          end else if (state == HOLD) begin
            state <= Stall ? HOLD : FETCH;
          end else if (Stall) begin
            state <= HOLD;
          end else if (legal) begin
            Instr <= ITM;
            PCOut <= pc;
            Valid <= 1'b1;
            pc    <= pc + 32'd4;
            if (FetchCnt != 16'hFFFF) FetchCnt <= FetchCnt + 16'd1;
          end else begin
            Valid <= 1'b0;
            Fault <= 1'b1;
            state <= FAULT;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: randomized + directed fetch traffic against a behavioural model via a per-cycle scoreboard.
module tb_ifetch_ctrl;
  localparam int          MB  = 400;
  localparam logic [31:0] RPC = 32'h0000_0000;
  logic        clk = 1'b0, rst_n = 1'b0, Enable = 1'b0, Stall = 1'b0, BrTaken = 1'b0;
  logic [31:0] BrTarget = '0, ITM, RAdrs, Instr, PCOut;
  logic        Valid, Fault;
  logic [15:0] FetchCnt;
  logic [31:0] mem [MB/4];
  typedef struct {
    logic [31:0] pc, instr, pcout;
    logic        valid, fault;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t me;
  bit          active, stalled, dead;
  logic [31:0] m_pc, m_instr, m_pcout;
  logic        m_valid, m_fault;
  int          m_cnt;
  int          vectors = 0, miscompares = 0;

  ifetch_ctrl #(.MEM_BYTES(MB), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .Enable(Enable), .Stall(Stall), .BrTaken(BrTaken),
    .BrTarget(BrTarget), .ITM(ITM), .RAdrs(RAdrs), .Instr(Instr), .PCOut(PCOut),
    .Valid(Valid), .Fault(Fault), .FetchCnt(FetchCnt)
  );

  always #5 clk = ~clk;
  always_comb ITM = (RAdrs < MB) ? mem[int'(RAdrs >> 2)] : 32'hBAD0_BAD0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (q.size() > 0) begin
    me = q.pop_front();
    chk("RAdrs", RAdrs, me.pc);
    chk("Instr", Instr, me.instr);
    chk("PCOut", PCOut, me.pcout);
    chk("Valid", 32'(Valid), 32'(me.valid));
    chk("Fault", 32'(Fault), 32'(me.fault));
    chk("FetchCnt", 32'(FetchCnt), 32'(me.cnt));
  end

  function automatic bit is_legal(input logic [31:0] a);
    return a[1:0] == 2'b00 && longint'(a) + 3 < longint'(MB);
  endfunction

  task automatic model_reset();
    active = 0; stalled = 0; dead = 0;
    m_pc = RPC; m_instr = 0; m_pcout = 0; m_valid = 0; m_fault = 0; m_cnt = 0;
  endtask

  // One clock of fetch behaviour, from the stage's rules rather than any state encoding
  task automatic model_step(input bit e, input bit s, input bit b, input logic [31:0] t);
    if (dead) return;
    if (!active) begin
      active = e;
    end else if (!e) begin
      active = 0; stalled = 0; m_valid = 0;
      if (b) m_pc = t;
    end else if (b) begin
      m_pc = t; m_valid = 0; stalled = 0;
    end else if (stalled) begin
      stalled = s;
    end else if (s) begin
      stalled = 1;
    end else if (is_legal(m_pc)) begin
      m_instr = mem[int'(m_pc >> 2)]; m_pcout = m_pc; m_valid = 1;
      m_pc = m_pc + 4;
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else begin
      m_valid = 0; m_fault = 1; dead = 1;
    end
  endtask

  task automatic tick(input bit e, input bit s, input bit b, input logic [31:0] t);
    Enable = e; Stall = s; BrTaken = b; BrTarget = t;
    @(posedge clk);
    model_step(e, s, b, t);
    q.push_back('{pc: m_pc, instr: m_instr, pcout: m_pcout, valid: m_valid, fault: m_fault, cnt: 16'(m_cnt)});
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge
  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_RAdrs", RAdrs, RPC);
    chk("rst_Instr", Instr, 32'h0);
    chk("rst_PCOut", PCOut, 32'h0);
    chk("rst_flags", {29'h0, Valid, Fault, |FetchCnt}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [31:0] t;
    int r;
    for (int i = 0; i < MB/4; i++) mem[i] = $urandom;
    model_reset();
    do_reset();
    run(3);
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0);
    run(3);
    tick(1, 1, 1, 32'h40);
    run(2);
    tick(1, 0, 1, 32'h18E);
    run(2);
    tick(0, 1, 1, 32'h8);
    tick(1, 0, 1, 32'h40);
    tick(0, 0, 0, 0);
    tick(1, 0, 0, 0);
    do_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 1, 32'h22);
    run(2);
    do_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 1, MB - 8);
    run(4);
    do_reset();
    run(3);
    tick(0, 0, 1, 32'h10);
    tick(0, 0, 0, 0);
    run(3);
    tick(1, 1, 0, 0);
    tick(0, 1, 0, 0);
    run(3);
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 60 == 59) do_reset();
      r = $urandom_range(0, 9);
      t = (r < 7) ? {22'h0, 8'($urandom_range(0, MB/4 - 1)), 2'b00} :
          (r == 7) ? MB - 8 :
          (r == 8) ? {22'h0, 8'($urandom_range(0, MB/4 - 1)), 2'b10} : $urandom;
      tick($urandom_range(0, 15) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, t);
    end
    @(negedge clk); #1;
    if (q.size() != 0) chk("queue_drain", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ifetch_ctrl.md
IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 Parameter MEM_BYTES, default 400, SHALL give the instruction-memory size in bytes.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL give the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Enable  input  1  SHALL start fetching: 1 = run, 0 = remain idle.
REQ-006 Stall  input  1  SHALL freeze the fetch stage when high.
REQ-007 BrTaken  input  1  SHALL request a PC redirect to BrTarget.
REQ-008 BrTarget  input  32  SHALL give the redirect byte address.
REQ-009 ITM  input  32  SHALL carry the instruction word returned combinationally by the instruction memory for RAdrs.
REQ-010 RAdrs  output  32  SHALL drive the byte read address to the instruction memory.
REQ-011 Instr  output  32  SHALL present the registered fetched instruction.
REQ-012 PCOut  output  32  SHALL present the byte address Instr was fetched from.
REQ-013 Valid  output  1  SHALL be high when Instr/PCOut hold a live instruction.
REQ-014 Fault  output  1  SHALL flag a sticky fetch-address fault.
REQ-015 FetchCnt  output  16  SHALL count instructions delivered.

Function
REQ-016 The block SHALL hold a 32-bit PC register; RAdrs SHALL equal PC combinationally in every state.
REQ-017 States SHALL be IDLE, FETCH, HOLD, FAULT.
REQ-018 IDLE: Valid 0; Enable=1 -> FETCH next edge; PC unchanged.
REQ-019 FETCH, no Stall, no BrTaken, PC legal: Instr<=ITM, PCOut<=PC, Valid<=1, PC<=PC+4, FetchCnt+1 (one-cycle latency from RAdrs to Instr).
REQ-020 FETCH with Stall=1 and BrTaken=0: Instr, PCOut, Valid, PC, FetchCnt held; -> HOLD.
REQ-021 HOLD: outputs and PC held while Stall=1; Stall=0 -> FETCH next edge, first fetch of the resumed PC in that FETCH cycle.
REQ-022 BrTaken=1 in FETCH or HOLD SHALL have priority over Stall: PC<=BrTarget, Valid<=0 (one bubble), FetchCnt unchanged, -> FETCH.
REQ-023 PC is legal only if PC[1:0]==2'b00 and PC+3 < MEM_BYTES; checked when the fetch would be captured.
REQ-024 Illegal PC in FETCH (not stalled, not branching): Valid<=0, Fault<=1, -> FAULT; PC frozen at the faulting address.
REQ-025 FAULT SHALL be absorbing: ignores Enable, Stall, BrTaken; Fault stays 1 until rst_n asserted.
REQ-026 Enable=0 in FETCH or HOLD SHALL return to IDLE next edge with Valid<=0, PC retained; BrTaken in the same cycle still updates PC.
REQ-027 FetchCnt SHALL saturate at 16'hFFFF.
REQ-028 PC+4 SHALL wrap modulo 2^32 (the wrapped value is caught by REQ-023).

Reset
REQ-029 rst_n=0 SHALL immediately force: state IDLE, PC=RESET_PC, Instr=0, PCOut=0, Valid=0, Fault=0, FetchCnt=0, regardless of clk.
REQ-030 Reset asserted mid-stall, mid-branch or in FAULT SHALL discard all in-flight state; first fetch after release requires Enable=1.

Verification
REQ-031 Reset release, Enable=1, memory words at 0,4,8 -> Valid rises one cycle after FETCH entry; PCOut 0,4,8 on consecutive cycles with matching Instr; FetchCnt 1,2,3.
REQ-032 Stall=1 for 3 cycles at PC=8 -> Instr/PCOut (addr 4) held, FetchCnt held at 2; after release next PCOut=8, no skip or duplicate.
REQ-033 BrTaken=1, BrTarget=0x40 with Stall=1 the same cycle -> next cycle Valid=0, PC=0x40; following cycle PCOut=0x40.
REQ-034 BrTarget=0x18E (MEM_BYTES=400) -> Fault=1, Valid=0, state FAULT; later BrTaken/Enable toggles leave Fault=1 until rst_n.
REQ-035 BrTarget=0x22 (misaligned) -> Fault=1 on first fetch attempt; rst_n pulse mid-cycle -> all outputs zero asynchronously, PC=RESET_PC.
REQ-036 Fetch run from PC=MEM_BYTES-8 -> two valid instructions, then Fault=1 at PC=MEM_BYTES-4+4.
